wb_arbiter_2x1: RTL and testbench

WB_ARBITER_2X1 -- requirements
Module: wb_arbiter_2x1

---
 rtl/wb_arbiter_2x1.sv | 180 ++++++++++++++++++
 tb/tb_wb_arbiter_2x1.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter_2x1.sv
// -----------------------------------------------------------------------------
// wb_arbiter_2x1
// Two-master, one-slave Wishbone arbiter with round-robin fairness and a
// bus-error timeout for slaves that never acknowledge.
//
// Ports
//   clk, rst                 : clock, synchronous active-high reset
//   m0_* (UART bridge)       : cyc/stb/we/adr/dat in, dat/ack/err out
//   m1_* (core)              : same as master 0
//   s_cyc_o .. s_dat_o       : slave request side, follows the owner
//   s_dat_i, s_ack_i         : slave read data and acknowledge
//   o_grant                  : one-hot owner (bit N = master N), zero in IDLE
//   o_m1_stall               : master 1 is requesting but does not own the bus
//   dbg_state_o              : current arbiter state (IDLE=0, GNT0=1, GNT1=2)
//
// Handshake: a master owns the slave from the cycle after its cyc is seen
// (one-cycle grant latency) until the cycle its cyc is seen low. While owning,
// its strobe and payload reach the slave combinationally and the slave's
// ack/data come straight back; a transfer completes in any cycle where
// stb=1 and ack=1. A timeout ends the tenure with a one-cycle err instead.
// -----------------------------------------------------------------------------
module wb_arbiter_2x1 #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  // master 0
  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_adr_i,
  input  logic [DATA_WIDTH-1:0] m0_dat_i,
  output logic [DATA_WIDTH-1:0] m0_dat_o,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  // master 1
  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_adr_i,
  input  logic [DATA_WIDTH-1:0] m1_dat_i,
  output logic [DATA_WIDTH-1:0] m1_dat_o,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  // slave
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [ADDR_WIDTH-1:0] s_adr_o,
  output logic [DATA_WIDTH-1:0] s_dat_o,
  input  logic [DATA_WIDTH-1:0] s_dat_i,
  input  logic                  s_ack_i,
  // status
  output logic [1:0]            o_grant,
  output logic                  o_m1_stall,
  output logic [1:0]            dbg_state_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  state_e          state_q;
  logic            last_q;   // master that was granted most recently
  logic [CW-1:0]   cnt_q;    // unacknowledged strobe cycles in this tenure
  logic [1:0]      grant_q;

  // Signals of whichever master currently owns the bus
  logic                  granted;
  logic                  sel_cyc;
  logic                  sel_stb;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_adr;
  logic [DATA_WIDTH-1:0] sel_dat;
  logic                  timeout_hit;
  logic                  ack_ok;

  always_comb begin
    granted = 1'b0;
    sel_cyc = 1'b0;
    sel_stb = 1'b0;
    sel_we  = 1'b0;
    sel_adr = '0;
    sel_dat = '0;
    case (state_q)
      GNT0: begin
        granted = 1'b1;
        sel_cyc = m0_cyc_i;
        sel_stb = m0_stb_i;
        sel_we  = m0_we_i;
        sel_adr = m0_adr_i;
        sel_dat = m0_dat_i;
      end
      GNT1: begin
        granted = 1'b1;
        sel_cyc = m1_cyc_i;
        sel_stb = m1_stb_i;
        sel_we  = m1_we_i;
        sel_adr = m1_adr_i;
        sel_dat = m1_dat_i;
      end
      default: ;
    endcase
  end

  // This strobe cycle would be the TIMEOUT-th unacknowledged one. An ack in
  // the same cycle takes priority, so it suppresses the timeout.
  assign timeout_hit = granted && sel_cyc && sel_stb && !s_ack_i && !rst &&
                       (cnt_q == CW'(TIMEOUT - 1));

  // A reset edge aborts the tenure, so no completion is reported during it.
  assign ack_ok = s_ack_i && !rst;

  // Slave side: the owner's request, with cyc/stb pulled low on timeout
  assign s_cyc_o = sel_cyc && !timeout_hit;
  assign s_stb_o = sel_stb && !timeout_hit;
  assign s_we_o  = sel_we;
  assign s_adr_o = sel_adr;
  assign s_dat_o = sel_dat;

  // Master side: only the owner sees the slave's response
  assign m0_dat_o = (state_q == GNT0) ? s_dat_i : '0;
  assign m1_dat_o = (state_q == GNT1) ? s_dat_i : '0;
  assign m0_ack_o = (state_q == GNT0) && ack_ok;
  assign m1_ack_o = (state_q == GNT1) && ack_ok;
  assign m0_err_o = (state_q == GNT0) && timeout_hit;
  assign m1_err_o = (state_q == GNT1) && timeout_hit;

  assign o_grant     = grant_q;
  assign o_m1_stall  = m1_cyc_i && (state_q != GNT1);
  assign dbg_state_o = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;   // master 0 wins the first contention
      cnt_q   <= '0;
      grant_q <= 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          // Master 0 wins if alone, or if both ask and master 1 went last
          if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
            state_q <= GNT0;
            last_q  <= 1'b0;
            grant_q <= 2'b01;
          end else if (m1_cyc_i) begin
            state_q <= GNT1;
            last_q  <= 1'b1;
            grant_q <= 2'b10;
          end
        end
        GNT0, GNT1: begin
          if (timeout_hit || !sel_cyc) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            cnt_q   <= '0;
          end else if (s_ack_i) begin
            cnt_q <= '0;
          end else if (sel_stb) begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= 2'b00;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter_2x1.sv
module tb_wb_arbiter_2x1;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- stimulus ----------------
  logic          mcyc [2];
  logic          mstb [2];
  logic          mwe  [2];
  logic [AW-1:0] madr [2];
  logic [DW-1:0] mdat [2];
  logic [DW-1:0] s_dat;
  logic          s_ack;

  // ---------------- DUT outputs ----------------
  logic [DW-1:0] m0_dat_o, m1_dat_o;
  logic          m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic          s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0] s_adr_o;
  logic [DW-1:0] s_dat_o;
  logic [1:0]    o_grant;
  logic          o_m1_stall;
  logic [1:0]    dbg_state;

  wb_arbiter_2x1 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc_i(mcyc[0]), .m0_stb_i(mstb[0]), .m0_we_i(mwe[0]),
    .m0_adr_i(madr[0]), .m0_dat_i(mdat[0]),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(mcyc[1]), .m1_stb_i(mstb[1]), .m1_we_i(mwe[1]),
    .m1_adr_i(madr[1]), .m1_dat_i(mdat[1]),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_dat_i(s_dat), .s_ack_i(s_ack),
    .o_grant(o_grant), .o_m1_stall(o_m1_stall), .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int err_seen = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // owner: -1 no owner, else the master that holds the bus this cycle.
  // last: master that was given the bus most recently.
  // pending: strobe cycles without an ack in the current tenure.
  int owner   = -1;
  int last    = 1;
  int pending = 0;
  bit model_ok = 0;

  function automatic bit model_timeout();
    if (owner < 0 || rst) return 0;
    return mcyc[owner] && mstb[owner] && !s_ack && (pending + 1 == TO);
  endfunction

  task automatic compare_all();
    bit th;
    int o;
    th = model_timeout();
    o  = (owner < 0) ? 0 : owner;
    check_eq("grant", o_grant, (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00);
    check_eq("m1_stall", o_m1_stall, mcyc[1] && owner != 1);
    check_eq("s_cyc", s_cyc_o, (owner >= 0) && mcyc[o] && !th);
    check_eq("s_stb", s_stb_o, (owner >= 0) && mstb[o] && !th);
    check_eq("s_we",  s_we_o,  (owner >= 0) && mwe[o]);
    check_eq("s_adr", s_adr_o, (owner >= 0) ? madr[o] : '0);
    check_eq("s_dat", s_dat_o, (owner >= 0) ? mdat[o] : '0);
    check_eq("m0_dat", m0_dat_o, (owner == 0) ? s_dat : '0);
    check_eq("m1_dat", m1_dat_o, (owner == 1) ? s_dat : '0);
    check_eq("m0_ack", m0_ack_o, (owner == 0) && s_ack && !rst);
    check_eq("m1_ack", m1_ack_o, (owner == 1) && s_ack && !rst);
    check_eq("m0_err", m0_err_o, (owner == 0) && th);
    check_eq("m1_err", m1_err_o, (owner == 1) && th);
  endtask

  task automatic model_next();
    bit th;
    th = model_timeout();
    if (rst) begin
      owner = -1; last = 1; pending = 0; model_ok = 1;
    end else if (owner < 0) begin
      pending = 0;
      if (mcyc[0] && mcyc[1]) owner = 1 - last;
      else if (mcyc[0])       owner = 0;
      else if (mcyc[1])       owner = 1;
      if (owner >= 0) last = owner;
    end else if (th || !mcyc[owner]) begin
      owner = -1; pending = 0;
    end else if (s_ack) begin
      pending = 0;
    end else if (mstb[owner]) begin
      pending++;
    end
  endtask

  // ---------------- driver tasks ----------------
  // sample: look at the DUT mid-cycle; advance: move the model and the clock.
  task automatic sample();
    @(negedge clk);
    if (m0_err_o) err_seen++;
    if (model_ok) compare_all();
  endtask

  task automatic advance();
    model_next();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      sample();
      advance();
    end
  endtask

  task automatic set_master(input int m, input bit cyc, input bit stb, input bit we,
                            input logic [AW-1:0] adr, input logic [DW-1:0] dat);
    mcyc[m] = cyc; mstb[m] = stb; mwe[m] = we; madr[m] = adr; mdat[m] = dat;
  endtask

  task automatic quiet();
    set_master(0, 0, 0, 0, '0, '0);
    set_master(1, 0, 0, 0, '0, '0);
    s_ack = 0; s_dat = '0;
  endtask

  task automatic do_reset();
    rst = 1;
    step(2);
    rst = 0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    quiet();
    do_reset();

    // Reset state
    sample();
    check_eq("reset_grant", o_grant, 2'b00);
    check_eq("reset_scyc", s_cyc_o, 1'b0);
    advance();

    // Single read by master 1, ack on the 2nd granted cycle
    set_master(1, 1, 1, 0, 32'h10, '0);
    step(1);
    sample();
    check_eq("single_grant", o_grant, 2'b10);
    check_eq("single_adr", s_adr_o, 32'h10);
    advance();
    s_ack = 1; s_dat = 32'hDEADBEEF;
    sample();
    check_eq("single_ack", m1_ack_o, 1'b1);
    check_eq("single_dat", m1_dat_o, 32'hDEADBEEF);
    advance();
    quiet();
    step(2);

    // Contention after reset: master 0 first, master 1 stalls
    do_reset();
    set_master(0, 1, 1, 1, 32'h20, 32'h1111);
    set_master(1, 1, 1, 0, 32'h30, '0);
    step(1);
    sample();
    check_eq("cont_grant0", o_grant, 2'b01);
    check_eq("cont_stall", o_m1_stall, 1'b1);
    advance();
    s_ack = 1;
    step(1);
    s_ack = 0;
    set_master(0, 0, 0, 0, '0, '0);
    sample();
    advance();
    sample();
    check_eq("cont_idle", o_grant, 2'b00);
    advance();
    sample();
    check_eq("cont_grant1", o_grant, 2'b10);
    advance();
    quiet();
    step(2);

    // Round-robin: both keep asking, each tenure is one acked transfer
    set_master(0, 1, 1, 0, 32'h40, '0);
    set_master(1, 1, 1, 0, 32'h44, '0);
    s_ack = 1;
    for (int i = 0; i < 12; i++) begin
      mcyc[0] = !(dbg_state == 2'd1);
      mcyc[1] = !(dbg_state == 2'd2);
      mstb[0] = mcyc[0];
      mstb[1] = mcyc[1];
      step(1);
    end
    quiet();
    step(2);

    // Block transfer: master 1 keeps cyc across 4 strobes, master 0 waits
    set_master(1, 1, 1, 1, 32'h0, 32'hA0);
    step(1);
    set_master(0, 1, 1, 0, 32'h80, '0);
    for (int i = 0; i < 4; i++) begin
      madr[1] = AW'(i * 4);
      mdat[1] = DW'(32'hA0 + i);
      s_ack = 0;
      step(1);
      s_ack = 1;
      sample();
      check_eq("block_no_m0", o_grant, 2'b10);
      advance();
    end
    s_ack = 0;
    set_master(1, 0, 0, 0, '0, '0);
    step(2);
    sample();
    check_eq("block_then_m0", o_grant, 2'b01);
    advance();
    quiet();
    step(2);

    // Timeout: master 0 strobes, slave never acks
    set_master(0, 1, 1, 0, 32'hF0, '0);
    step(1);
    err_seen = 0;
    step(TO - 1);
    sample();
    check_eq("to_err", m0_err_o, 1'b1);
    check_eq("to_scyc", s_cyc_o, 1'b0);
    advance();
    sample();
    check_eq("to_idle", o_grant, 2'b00);
    advance();
    step(2);
    quiet();
    step(2);
    check_eq("to_err_pulses", err_seen, 1);

    // Timeout boundary with ack on the would-be timeout cycle
    set_master(0, 1, 1, 0, 32'hF4, '0);
    step(1);
    err_seen = 0;
    step(TO - 1);
    s_ack = 1; s_dat = 32'h5A5A5A5A;
    sample();
    check_eq("to_ack_wins", m0_ack_o, 1'b1);
    check_eq("to_ack_noerr", m0_err_o, 1'b0);
    advance();
    s_ack = 0;
    step(3);
    check_eq("to_ack_pulses", err_seen, 0);
    quiet();
    step(2);

    // Reset in the middle of a master 1 tenure
    set_master(1, 1, 1, 0, 32'h50, '0);
    step(2);
    rst = 1; s_ack = 1;
    step(1);
    rst = 0;
    sample();
    check_eq("rst_grant", o_grant, 2'b00);
    check_eq("rst_m1_ack", m1_ack_o, 1'b0);
    check_eq("rst_m1_err", m1_err_o, 1'b0);
    check_eq("rst_scyc", s_cyc_o, 1'b0);
    advance();
    quiet();
    step(2);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      for (int m = 0; m < 2; m++) begin
        if ($urandom_range(0, 3) == 0) mcyc[m] = !mcyc[m];
        mstb[m] = mcyc[m] && ($urandom_range(0, 3) != 0);
        mwe[m]  = 1'($urandom_range(0, 1));
        madr[m] = $urandom;
        mdat[m] = $urandom;
      end
      s_ack = ($urandom_range(0, 9) < 3);
      s_dat = $urandom;
      rst   = ($urandom_range(0, 99) == 0);
      step(1);
    end
    rst = 0;
    quiet();
    step(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
